// File: rtl/memsoc_out_monitor.sv
// Debounced, timestamped event logger for the core OUT bus, read back by the host
// over a small Wishbone register window (STATUS, DATA, CTRL, CURRENT).
module memsoc_out_monitor #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0100,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [9:0]  core_out,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq
);

  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt  = 5'(FIFO_DEPTH);
  localparam logic [7:0]  StableMax = 8'(STABLE_CYCLES);

  logic [9:0]      sync1_q, sync2_q;
  logic [9:0]      cand_q, cand_d;
  logic [9:0]      cur_q, cur_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            accept;
  logic [15:0]     ts_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d, en_q, en_d;
  logic            ack_q;
  logic [31:0]     dat_q, dat_d, rdata;
  logic [25:0]     mem_q [FIFO_DEPTH];

  logic       req, empty, full, pop, ctrl_wr, flush, clr_ovf, push_req, do_push;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign unused_bits = ^{wbs_dat_i[31:3], wbs_sel_i[3:1], wbs_adr_i[1:0]};

  // Bus decode; the !ack term keeps a held strobe from issuing a second access.
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q
                 & (wbs_adr_i[31:4] == BASE_ADDRESS[31:4]);
  assign reg_sel = wbs_adr_i[3:2];
  assign empty   = (count_q == 5'd0);
  assign full    = (count_q == DepthCnt);
  assign pop     = req & ~wbs_we_i & (reg_sel == 2'd1) & ~empty;
  assign ctrl_wr = req & wbs_we_i & (reg_sel == 2'd2) & wbs_sel_i[0];
  assign flush   = ctrl_wr & wbs_dat_i[1];
  assign clr_ovf = ctrl_wr & wbs_dat_i[2];

  // Debounce: accept once the candidate has been seen STABLE_CYCLES times in a row.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    cur_d  = cur_q;
    accept = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd1;
    end else begin
      if (cnt_q != StableMax) cnt_d = cnt_q + 8'd1;
      accept = (cnt_d == StableMax) && (cand_q != cur_q);
    end
    if (accept) cur_d = cand_q;
  end

  assign push_req = accept & en_q;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign do_push  = push_req & ~flush & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    en_d     = en_q;
    if (ctrl_wr) en_d = wbs_dat_i[0];
    if (clr_ovf) ovf_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !pop)      count_d = count_q + 5'd1;
      else if (pop && !do_push) count_d = count_q - 5'd1;
      if (push_req && full && !pop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (reg_sel)
      2'd0: rdata = {20'd0, en_q, ovf_q, full, empty, 3'd0, count_q};
      2'd1: rdata = empty ? 32'd0
                          : {mem_q[rd_ptr_q][25:10], 6'd0, mem_q[rd_ptr_q][9:0]};
      2'd2: rdata = {31'd0, en_q};
      2'd3: rdata = {6'd0, sync2_q, 6'd0, cur_q};
      default: rdata = 32'd0;
    endcase
  end

  assign dat_d = (req & ~wbs_we_i) ? rdata : 32'd0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      cur_q    <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      sync1_q  <= core_out;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      if (en_q) ts_q <= ts_q + 16'd1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      ack_q    <= req;
      dat_q    <= dat_d;
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= {ts_q, cand_q};
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = en_q & ~empty;

endmodule

// File: tb/tb_memsoc_out_monitor.sv
// Directed bench for memsoc_out_monitor: debounce timing, FIFO order, overflow,
// flush, address decode and reset during an acknowledge.
module tb_memsoc_out_monitor;

  localparam logic [31:0] Base = 32'h3000_0100;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [9:0]  core_out = '0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq;

  int checks = 0;
  int fails = 0;
  int edge_cnt = 0;
  int last_ack_edge = 0;
  logic        got_ack;
  logic [31:0] rd_data;

  memsoc_out_monitor #(
    .BASE_ADDRESS (Base),
    .FIFO_DEPTH   (8),
    .STABLE_CYCLES(4)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .core_out (core_out),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .irq      (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

  // One bus access, bounded to 8 cycles waiting for ack.
  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = addr;
    wbs_dat_i = wdata;
    wbs_sel_i = sel;
    got_ack   = 1'b0;
    rd_data   = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) begin
        got_ack       = 1'b1;
        rd_data       = wbs_dat_o;
        last_ack_edge = edge_cnt;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_dat_i = '0;
  endtask

  task automatic set_out(input logic [9:0] v);
    @(negedge wb_clk_i);
    core_out = v;
    repeat (8) @(negedge wb_clk_i);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if ({wbs_ack_o, wbs_dat_o, irq} !== 34'd0) begin
      $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, want all 0", wbs_ack_o, wbs_dat_o, irq);
      fails++;
    end
    wb_rst_i = 1'b0;
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0100 || !got_ack) begin
      $display("FAIL reset_status: got %h ack=%b, want 00000100", rd_data, got_ack);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'hC, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL reset_current: got %h irq=%b, want 0 irq=0", rd_data, irq);
      fails++;
    end
  endtask

  task automatic test_accept;
    int en_edge, k, p;
    logic [31:0] exp;
    wb_xfer(1'b1, Base + 32'h8, 32'h1, 4'h1);
    en_edge = last_ack_edge;
    @(negedge wb_clk_i);
    core_out = 10'h2A5;
    k = edge_cnt + 1;
    p = k + 5;
    do begin
      @(posedge wb_clk_i);
      #1;
    end while (edge_cnt < p - 1);
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL accept_early: irq=%b one cycle before acceptance, want 0", irq);
      fails++;
    end
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL accept_irq: irq=%b at acceptance, want 1", irq);
      fails++;
    end
    exp = {16'(p - en_edge - 1), 6'd0, 10'h2A5};
    wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
    checks++;
    if (rd_data !== exp) begin
      $display("FAIL accept_data: got %h, want %h", rd_data, exp);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0900 || irq !== 1'b0) begin
      $display("FAIL accept_status: got %h irq=%b, want 00000900 irq=0", rd_data, irq);
      fails++;
    end
  endtask

  task automatic test_glitch;
    @(negedge wb_clk_i);
    core_out = 10'h001;
    repeat (2) @(negedge wb_clk_i);
    core_out = 10'h2A5;
    repeat (10) @(negedge wb_clk_i);
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0900) begin
      $display("FAIL glitch_status: got %h, want 00000900", rd_data);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'hC, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h02A5_02A5) begin
      $display("FAIL glitch_current: got %h, want 02a502a5", rd_data);
      fails++;
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 9; i++) set_out(10'h100 + 10'(i));
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0E08 || irq !== 1'b1) begin
      $display("FAIL ovf_status: got %h irq=%b, want 00000e08 irq=1", rd_data, irq);
      fails++;
    end
    for (int i = 1; i <= 8; i++) begin
      wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
      checks++;
      if (rd_data[9:0] !== 10'h100 + 10'(i)) begin
        $display("FAIL ovf_pop%0d: got %h, want %h", i, rd_data[9:0], 10'h100 + 10'(i));
        fails++;
      end
    end
    wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'd0 || !got_ack) begin
      $display("FAIL ovf_empty_read: got %h ack=%b, want 0 ack=1", rd_data, got_ack);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0D00) begin
      $display("FAIL ovf_sticky: got %h, want 00000d00", rd_data);
      fails++;
    end
    wb_xfer(1'b1, Base + 32'h8, 32'h5, 4'h1);
    wb_xfer(1'b0, Base + 32'h8, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'd1) begin
      $display("FAIL ctrl_readback: got %h, want 00000001", rd_data);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0900) begin
      $display("FAIL ovf_clear: got %h, want 00000900", rd_data);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    int k, p;
    for (int i = 1; i <= 8; i++) set_out(10'h200 + 10'(i));
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0A08) begin
      $display("FAIL b2b_full: got %h, want 00000a08", rd_data);
      fails++;
    end
    @(negedge wb_clk_i);
    core_out = 10'h3FF;
    k = edge_cnt + 1;
    p = k + 5;
    repeat (4) @(negedge wb_clk_i);
    wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
    checks++;
    if (rd_data[9:0] !== 10'h201 || last_ack_edge !== p) begin
      $display("FAIL b2b_pop: got %h at edge %0d, want 201 at edge %0d",
               rd_data[9:0], last_ack_edge, p);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0A08) begin
      $display("FAIL b2b_status: got %h, want 00000a08", rd_data);
      fails++;
    end
    for (int i = 2; i <= 9; i++) begin
      logic [9:0] exp;
      exp = (i == 9) ? 10'h3FF : 10'h200 + 10'(i);
      wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
      checks++;
      if (rd_data[9:0] !== exp) begin
        $display("FAIL b2b_order%0d: got %h, want %h", i, rd_data[9:0], exp);
        fails++;
      end
    end
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0900) begin
      $display("FAIL b2b_drained: got %h, want 00000900", rd_data);
      fails++;
    end
  endtask

  task automatic test_flush;
    set_out(10'h011);
    set_out(10'h022);
    set_out(10'h033);
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0803 || irq !== 1'b1) begin
      $display("FAIL flush_pre: got %h irq=%b, want 00000803 irq=1", rd_data, irq);
      fails++;
    end
    wb_xfer(1'b1, Base + 32'h8, 32'h3, 4'h1);
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0900 || irq !== 1'b0) begin
      $display("FAIL flush_post: got %h irq=%b, want 00000900 irq=0", rd_data, irq);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'h4, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'd0) begin
      $display("FAIL flush_data: got %h, want 0", rd_data);
      fails++;
    end
  endtask

  task automatic test_bad_addr;
    wb_xfer(1'b0, Base + 32'h10, 32'd0, 4'hF);
    checks++;
    if (got_ack !== 1'b0 || wbs_dat_o !== 32'd0) begin
      $display("FAIL bad_addr: ack=%b dat=%h, want no ack and 0", got_ack, wbs_dat_o);
      fails++;
    end
  endtask

  task automatic test_reset_mid;
    set_out(10'h155);
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL rst_mid_pre: irq=%b, want 1", irq);
      fails++;
    end
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = Base;
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      $display("FAIL rst_mid_ack: ack=%b, want 1", wbs_ack_o);
      fails++;
    end
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL rst_mid_drop: ack=%b dat=%h irq=%b, want 0", wbs_ack_o, wbs_dat_o, irq);
      fails++;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    wb_xfer(1'b0, Base + 32'h0, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0000_0100) begin
      $display("FAIL rst_mid_status: got %h, want 00000100", rd_data);
      fails++;
    end
    wb_xfer(1'b0, Base + 32'hC, 32'd0, 4'hF);
    checks++;
    if (rd_data !== 32'h0155_0155) begin
      $display("FAIL rst_mid_current: got %h, want 01550155", rd_data);
      fails++;
    end
  endtask

  initial begin
    test_reset;
    test_accept;
    test_glitch;
    test_overflow;
    test_back_to_back;
    test_flush;
    test_bad_addr;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
